pin_lock_fsm: RTL and testbench

//  Parametrised digital-lock controller: the user sets a PIN of PIN_LEN one-hot key presses, then

---
 rtl/pin_lock_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_pin_lock_fsm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pin_lock_fsm.sv
// Digital PIN lock: set/confirm a PIN of one-hot key presses, then unlock by re-entry with
// failed-attempt lockout and idle timeout. All outputs registered, one cycle after the press.
module pin_lock_fsm #(
  parameter int N              = 4,
  parameter int PIN_LEN        = 4,
  parameter int ALLOW_REPEAT   = 0,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N-1:0]                     key,
  output logic                             locked,
  output logic                             lockout,
  output logic                             error,
  output logic [$clog2(PIN_LEN+1)-1:0]     digit_count,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count,
  output logic [1:0]                       mode
);

  localparam int DCW  = $clog2(PIN_LEN+1);
  localparam int FCW  = $clog2(MAX_TRIES+1);
  localparam int IW   = $clog2(PIN_LEN);
  localparam int LW   = $clog2(LOCKOUT_CYCLES+1);
  localparam int TLIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int TW   = $clog2(TLIM+2);
  localparam logic [DCW-1:0] LAST = DCW'(PIN_LEN-1);

  typedef enum logic [1:0] {
    ST_SET     = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [N-1:0]                key_q;
  logic [PIN_LEN-1:0][N-1:0]   pin_q, pin_d;
  logic [PIN_LEN-1:0][N-1:0]   entry_q, entry_d;
  logic [PIN_LEN-1:0][N-1:0]   cand;
  logic [DCW-1:0]              dc_q, dc_d;
  logic [FCW-1:0]              fail_q, fail_d;
  logic [LW-1:0]               lock_cnt_q, lock_cnt_d;
  logic [TW-1:0]               idle_q, idle_d;
  logic                        err_q, err_d;

  logic          press, valid, dup, full_match, timeout;
  logic [IW-1:0] slot;

  assign press = (|key) && !(|key_q);
  assign valid = $onehot(key);
  assign slot  = dc_q[IW-1:0];

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < PIN_LEN; i++) begin
      if ((ALLOW_REPEAT == 0) && (i < int'(dc_q)) && (pin_q[i] == key)) dup = 1'b1;
    end
  end

  // Unlock compares the whole buffered entry plus the final key, so a wrong digit is never hinted.
  always_comb begin
    cand       = entry_q;
    cand[PIN_LEN-1] = key;
    full_match = (cand == pin_q);
  end

  assign timeout = (TIMEOUT_CYCLES != 0) && (idle_q == TW'(TLIM)) && (dc_q != '0);

  always_comb begin
    if (press)                     idle_d = '0;
    else if (idle_q == TW'(TLIM))  idle_d = idle_q;
    else                           idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_SET;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pin_d      = pin_q;
    entry_d    = entry_q;
    dc_d       = dc_q;
    fail_d     = fail_q;
    lock_cnt_d = lock_cnt_q;
    err_d      = 1'b0;
    case (state_q)
      ST_SET: begin
        if (press) begin
          if (!valid || dup) begin
            err_d = 1'b1;
            dc_d  = '0;
          end else begin
            pin_d[slot] = key;
            if (dc_q == LAST) begin
              state_d = ST_CONFIRM;
              dc_d    = '0;
            end else begin
              dc_d = dc_q + 1'b1;
            end
          end
        end else if (timeout) begin
          dc_d = '0;
        end
      end
      ST_CONFIRM: begin
        if (press) begin
          if (!valid || (key != pin_q[slot])) begin
            err_d   = 1'b1;
            pin_d   = '0;
            dc_d    = '0;
            state_d = ST_SET;
          end else if (dc_q == LAST) begin
            state_d = ST_LOCKED;
            dc_d    = '0;
            fail_d  = '0;
          end else begin
            dc_d = dc_q + 1'b1;
          end
        end else if (timeout) begin
          pin_d   = '0;
          dc_d    = '0;
          state_d = ST_SET;
        end
      end
      ST_LOCKED: begin
        if (press) begin
          if (!valid) begin
            err_d   = 1'b1;
            dc_d    = '0;
            entry_d = '0;
          end else if (dc_q == LAST) begin
            dc_d    = '0;
            entry_d = '0;
            if (full_match) begin
              state_d = ST_SET;
              pin_d   = '0;
              fail_d  = '0;
            end else begin
              err_d = 1'b1;
              if (fail_q >= FCW'(MAX_TRIES-1)) begin
                fail_d     = FCW'(MAX_TRIES);
                state_d    = ST_LOCKOUT;
                lock_cnt_d = LW'(LOCKOUT_CYCLES);
              end else begin
                fail_d = fail_q + 1'b1;
              end
            end
          end else begin
            entry_d[slot] = key;
            dc_d          = dc_q + 1'b1;
          end
        end else if (timeout) begin
          dc_d    = '0;
          entry_d = '0;
        end
      end
      ST_LOCKOUT: begin
        if (lock_cnt_q <= LW'(1)) begin
          state_d    = ST_LOCKED;
          lock_cnt_d = '0;
          fail_d     = '0;
          dc_d       = '0;
        end else begin
          lock_cnt_d = lock_cnt_q - 1'b1;
        end
      end
      default: state_d = ST_SET;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_q      <= '0;
      pin_q      <= '0;
      entry_q    <= '0;
      dc_q       <= '0;
      fail_q     <= '0;
      lock_cnt_q <= '0;
      idle_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      key_q      <= key;
      pin_q      <= pin_d;
      entry_q    <= entry_d;
      dc_q       <= dc_d;
      fail_q     <= fail_d;
      lock_cnt_q <= lock_cnt_d;
      idle_q     <= idle_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    locked      = (state_q == ST_LOCKED) || (state_q == ST_LOCKOUT);
    lockout     = (state_q == ST_LOCKOUT);
    mode        = state_q;
    error       = err_q;
    digit_count = dc_q;
    fail_count  = fail_q;
  end

endmodule

// File: tb/tb_pin_lock_fsm.sv
// Directed bench for pin_lock_fsm: vector table for set/confirm/lock/failures, hand sequences
// for lockout timing, held keys, repeats, idle timeout and mid-sequence reset.
module tb_pin_lock_fsm;

  logic       clock;
  logic       reset;
  logic [3:0] key;
  logic       locked, lockout, error;
  logic [2:0] digit_count;
  logic [1:0] fail_count;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  pin_lock_fsm #(
    .N(4), .PIN_LEN(4), .ALLOW_REPEAT(0), .MAX_TRIES(3),
    .LOCKOUT_CYCLES(16), .TIMEOUT_CYCLES(32)
  ) dut (
    .clock(clock), .reset(reset), .key(key),
    .locked(locked), .lockout(lockout), .error(error),
    .digit_count(digit_count), .fail_count(fail_count), .mode(mode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] k;
    logic       e_err;
    int         e_dc;
    int         e_fail;
    int         e_mode;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic [3:0] k);
    key = k;
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    step(k);
    step(4'b0000);
  endtask

  task automatic add(input logic [3:0] k, input logic e, input int dc, input int f, input int m);
    vec_t v;
    v.k = k; v.e_err = e; v.e_dc = dc; v.e_fail = f; v.e_mode = m;
    vq.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    key   = 4'b0000;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    key   = 4'b0000;
    #23;
    check("rst_mode", mode, 0);
    check("rst_locked", locked, 0);
    check("rst_lockout", lockout, 0);
    check("rst_error", error, 0);
    check("rst_dc", digit_count, 0);
    check("rst_fail", fail_count, 0);
    @(posedge clock); #1;
    reset = 1'b1;

    // set, confirm, then three wrong unlock attempts ending in lockout
    add(4'd1, 0, 1, 0, 0); add(4'd2, 0, 2, 0, 0); add(4'd4, 0, 3, 0, 0); add(4'd8, 0, 0, 0, 1);
    add(4'd1, 0, 1, 0, 1); add(4'd2, 0, 2, 0, 1); add(4'd4, 0, 3, 0, 1); add(4'd8, 0, 0, 0, 2);
    for (int a = 1; a <= 3; a++) begin
      add(4'd1, 0, 1, a-1, 2); add(4'd2, 0, 2, a-1, 2); add(4'd4, 0, 3, a-1, 2);
      add(4'd1, 1, 0, a, (a == 3) ? 3 : 2);
    end
    foreach (vq[i]) begin
      step(vq[i].k);
      check($sformatf("v%0d_err", i), error, vq[i].e_err);
      check($sformatf("v%0d_dc", i), digit_count, vq[i].e_dc);
      check($sformatf("v%0d_fail", i), fail_count, vq[i].e_fail);
      check($sformatf("v%0d_mode", i), mode, vq[i].e_mode);
      check($sformatf("v%0d_locked", i), locked, (vq[i].e_mode >= 2) ? 1 : 0);
      step(4'b0000);
      check($sformatf("v%0d_errclr", i), error, 0);
    end

    // lockout entered at edge E; table release was E+1
    check("lo_flag", lockout, 1);
    step(4'b0010);
    check("lo_ign_err", error, 0);
    check("lo_ign_dc", digit_count, 0);
    step(4'b0000);
    repeat (12) step(4'b0000);
    check("lo_e15_mode", mode, 3);
    step(4'b0000);
    check("lo_exit_mode", mode, 2);
    check("lo_exit_fail", fail_count, 0);
    check("lo_exit_lockout", lockout, 0);
    check("lo_exit_locked", locked, 1);

    // partial entry in LOCKED times out silently
    press(4'd1);
    press(4'd2);
    check("to_dc2", digit_count, 2);
    repeat (29) step(4'b0000);
    check("to_before", digit_count, 2);
    repeat (2) step(4'b0000);
    check("to_after_dc", digit_count, 0);
    check("to_after_err", error, 0);
    check("to_after_fail", fail_count, 0);
    check("to_after_mode", mode, 2);
    press(4'd1); press(4'd2); press(4'd4);
    step(4'd8);
    check("unl_mode", mode, 0);
    check("unl_locked", locked, 0);
    check("unl_err", error, 0);
    step(4'b0000);

    // held key, repeat rejection, multi-bit press
    do_reset();
    repeat (10) step(4'b0010);
    check("hold_dc", digit_count, 1);
    step(4'b0000);
    step(4'b0010);
    check("dup_err", error, 1);
    check("dup_dc", digit_count, 0);
    step(4'b0000);
    check("dup_errclr", error, 0);
    press(4'd1);
    step(4'd1);
    check("dup11_err", error, 1);
    check("dup11_dc", digit_count, 0);
    step(4'b0000);
    press(4'd4);
    step(4'b0011);
    check("multi_err", error, 1);
    check("multi_dc", digit_count, 0);
    check("multi_mode", mode, 0);
    step(4'b0000);

    // async reset mid-CONFIRM loses the PIN
    press(4'd1); press(4'd2); press(4'd4); press(4'd8);
    press(4'd1); press(4'd2);
    check("pre_rst_mode", mode, 1);
    check("pre_rst_dc", digit_count, 2);
    #2;
    reset = 1'b0;
    #1;
    check("arst_mode", mode, 0);
    check("arst_dc", digit_count, 0);
    check("arst_locked", locked, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    press(4'd1); press(4'd2); press(4'd4); press(4'd8);
    check("oldpin_mode", mode, 1);
    check("oldpin_locked", locked, 0);

    // timeout in CONFIRM returns to SET
    press(4'd1);
    check("cto_dc", digit_count, 1);
    repeat (40) step(4'b0000);
    check("cto_mode", mode, 0);
    check("cto_dc0", digit_count, 0);
    check("cto_err", error, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
